// File: rtl/seq_mult_pkg.sv
// Shared types and width helpers for the iterative shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
module rca_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        logic w_p;
        assign w_p             = i_a[gi] ^ i_b[gi];
        assign o_sum[gi]       = w_p ^ w_carry[gi];
        assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & w_p);
    end

    assign o_cout = w_carry[N];

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-and-add multiplier, one partial-product add per clock.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [WIDTH-1:0]         i_b,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [2*WIDTH-1:0]       o_product,
    output logic                     o_busy
);

    localparam int unsigned PW = prod_w(WIDTH);

    if (WIDTH < 2) begin : g_width_check
        $error("seq_mult: WIDTH must be at least 2");
    end

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_product;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [PW-1:0]    w_acc_next;
    logic [WIDTH-1:0] w_a_lat;
    logic [WIDTH-1:0] w_b_lat;
    logic [PW-1:0]    w_prod_final;

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;

    // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits unsigned.
    assign w_a_lat      = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_b_lat      = i_b[WIDTH-1] ? -i_b : i_b;
    assign w_prod_final = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
        end
    end
`else
    assign w_a_lat      = i_a;
    assign w_b_lat      = i_b;
    assign w_prod_final = w_acc_next;
`endif

    assign w_addend   = r_acc[0] ? r_mcand : '0;
    // Carry-out re-enters at the MSB as the accumulator shifts right.
    assign w_acc_next = {w_cout, w_sum, r_acc[WIDTH-1:1]};

    rca_adder #(
        .N (WIDTH)
    ) u_adder (
        .i_a    (r_acc[PW-1:WIDTH]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_busy       = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                o_busy = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= w_a_lat;
            r_acc   <= {{WIDTH{1'b0}}, w_b_lat};
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_prod_final;
            end
        end
    end

    assign o_product = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (WIDTH=8 and WIDTH=16 instances).
// Expected values follow SEQ_MULT_SIGNED_EN when it is defined.
module tb_seq_mult;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        out_valid16;
    logic [31:0] product16;
    logic        busy16;

    int n_checks;
    int n_fail;

    vec_t vecs[7];

    seq_mult #(
        .WIDTH (8)
    ) u_dut8 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_product   (product),
        .o_busy      (busy)
    );

    seq_mult #(
        .WIDTH (16)
    ) u_dut16 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid16),
        .o_in_ready  (in_ready16),
        .i_a         (a16),
        .i_b         (b16),
        .o_out_valid (out_valid16),
        .i_out_ready (1'b1),
        .o_product   (product16),
        .o_busy      (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full transaction on the 8-bit instance with out_ready held high.
    task automatic run_op8(input logic [7:0] va, input logic [7:0] vb,
                           input logic [15:0] exp, input string name);
        int lat;
        @(negedge clk);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd8);
        check({name, " product"}, 32'(product), 32'(exp));
        @(posedge clk);
        #1;
        check({name, " out_valid pulse"}, 32'(out_valid), 32'd0);
        check({name, " in_ready bubble"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        in_valid16 = 1'b0;
        a16        = '0;
        b16        = '0;

`ifdef SEQ_MULT_SIGNED_EN
        vecs[0] = '{a: 8'hFD, b: 8'h05, exp: 16'hFFF1, name: "s_m3x5"};
        vecs[1] = '{a: 8'h80, b: 8'h80, exp: 16'h4000, name: "s_m128xm128"};
        vecs[2] = '{a: 8'h80, b: 8'h01, exp: 16'hFF80, name: "s_m128x1"};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, exp: 16'h0001, name: "s_m1xm1"};
        vecs[4] = '{a: 8'h00, b: 8'hFD, exp: 16'h0000, name: "s_0xm3"};
        vecs[5] = '{a: 8'hFB, b: 8'h06, exp: 16'hFFE2, name: "s_m5x6"};
        vecs[6] = '{a: 8'h07, b: 8'h09, exp: 16'h003F, name: "s_7x9"};
`else
        vecs[0] = '{a: 8'd3,   b: 8'd5,   exp: 16'd15,    name: "u_3x5"};
        vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01,  name: "u_255x255"};
        vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0,     name: "u_0x200"};
        vecs[3] = '{a: 8'd200, b: 8'd0,   exp: 16'd0,     name: "u_200x0"};
        vecs[4] = '{a: 8'd128, b: 8'd2,   exp: 16'd256,   name: "u_128x2"};
        vecs[5] = '{a: 8'd1,   b: 8'd255, exp: 16'd255,   name: "u_1x255"};
        vecs[6] = '{a: 8'd7,   b: 8'd9,   exp: 16'd63,    name: "u_7x9"};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // Backpressure: DONE must hold everything and ignore in_valid
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'd3;
        b        = 8'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'd9;
            b        = 8'd9;
            @(posedge clk);
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp product", 32'(product), 32'd15);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp busy", 32'(busy), 32'd0);
        end
        // in_valid and out_ready together in DONE: only the output handshake happens
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release busy", 32'(busy), 32'd0);

        // Reset mid-operation at cnt=4
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'd7;
        b        = 8'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat   = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        check("midrst no result", 32'(lat), 32'd0);
        run_op8(8'd7, 8'd9, 16'd63, "post_rst_7x9");

        // 16-bit instance
        @(negedge clk);
        check("w16 in_ready", 32'(in_ready16), 32'd1);
        in_valid16 = 1'b1;
        a16        = 16'hFFFF;
        b16        = 16'h0002;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        a16        = 16'h1234;
        lat        = 0;
        while (!out_valid16 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w16 latency", 32'(lat), 32'd16);
`ifdef SEQ_MULT_SIGNED_EN
        check("w16 product", product16, 32'hFFFFFFFE);
`else
        check("w16 product", product16, 32'h0001FFFE);
`endif
        @(posedge clk);
        #1;
        check("w16 out_valid pulse", 32'(out_valid16), 32'd0);
        check("w16 busy", 32'(busy16), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
